// File: rtl/io_led_switch_ctrl.sv
// Memory-mapped LED output register and debounced switch input port.
// Combinational read path, registered LED writes, shared-count debouncer.
module io_led_switch_ctrl #(
    parameter logic [31:0] LED_BASE        = 32'hFFFF_FC60,
    parameter logic [31:0] SW_BASE         = 32'hFFFF_FC70,
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd200000
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        ioRead,
    input  logic        ioWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [23:0] switch_in,
    output logic [23:0] io_rdata,
    output logic [23:0] led_out
);

    localparam logic [31:0] LED_HI_ADDR = LED_BASE + 32'd2;
    localparam logic [31:0] SW_HI_ADDR  = SW_BASE + 32'd2;
    localparam logic [19:0] CNT_LAST    = DEBOUNCE_CYCLES - 20'd1;

    logic [23:0] r_led;
    logic [23:0] r_sync1;
    logic [23:0] r_sync2;
    logic [23:0] r_cand;
    logic [23:0] r_stable;
    logic [19:0] r_cnt;

    logic        w_led_lo;
    logic        w_led_hi;
    logic        w_sw_lo;
    logic        w_sw_hi;
    logic        w_unused;

    // Halfword decode: byte lane bit addr[0] plays no part.
    assign w_led_lo = (addr[31:1] == LED_BASE[31:1]);
    assign w_led_hi = (addr[31:1] == LED_HI_ADDR[31:1]);
    assign w_sw_lo  = (addr[31:1] == SW_BASE[31:1]);
    assign w_sw_hi  = (addr[31:1] == SW_HI_ADDR[31:1]);
    assign w_unused = ^{addr[0], wdata[31:16]};

    assign led_out = r_led;

    // LED register: each halfword window updates only its own bits.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_led <= '0;
        end else if (ioWrite) begin
            if (w_led_lo) begin
                r_led[15:0] <= wdata[15:0];
            end else if (w_led_hi) begin
                r_led[23:16] <= wdata[7:0];
            end
        end
    end

    // Two-flop synchronizer for the asynchronous board switches.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= switch_in;
            r_sync2 <= r_sync1;
        end
    end

    // Debouncer: any bit change restarts one shared saturating count.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_cand   <= '0;
            r_stable <= '0;
            r_cnt    <= '0;
        end else if (r_sync2 != r_cand) begin
            r_cand <= r_sync2;
            r_cnt  <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_stable <= r_cand;
        end else begin
            r_cnt <= r_cnt + 20'd1;
        end
    end

    // Read mux: zero unless a mapped window is read this cycle.
    always_comb begin
        io_rdata = '0;
        if (ioRead) begin
            unique case (1'b1)
                w_sw_lo:  io_rdata = {8'b0, r_stable[15:0]};
                w_sw_hi:  io_rdata = {16'b0, r_stable[23:16]};
                w_led_lo: io_rdata = {8'b0, r_led[15:0]};
                w_led_hi: io_rdata = {16'b0, r_led[23:16]};
                default:  io_rdata = '0;
            endcase
        end
    end

endmodule

// File: doc/io_led_switch_ctrl.md
Name: io_led_switch_ctrl

Overview:
- Memory-mapped I/O peripheral block, directly downstream of the memory/IO select stage.
- Consumes the CPU address, the ioRead/ioWrite strobes and the store data, and returns the 24-bit io_rdata that the select stage widens into the register write-back value.
- Owns a 24-bit LED output register and a 24-bit switch input path with a 2-flop synchronizer and debouncer.

Parameters:
- LED_BASE, 32'hFFFF_FC60, byte address of LED window (2 halfwords).
- SW_BASE, 32'hFFFF_FC70, byte address of switch window (2 halfwords).
- DEBOUNCE_CYCLES, 20'd200000, number of stable clocks required before a switch change is accepted; legal range 2..2^20-1.

Ports:
- clock  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ioRead  in  1  I/O read strobe from Controller.
- ioWrite  in  1  I/O write strobe from Controller.
- addr  in  32  I/O byte address (ALU result).
- wdata  in  32  store data.
- switch_in  in  24  raw board switches, asynchronous to clock.
- io_rdata  out  24  read data to the memory/IO select stage.
- led_out  out  24  board LEDs.

Behaviour:
- Reset is asynchronous on rst_n low and takes effect immediately. led_out = 0, sync flops = 0, candidate = 0, stable = 0, counter = 0, io_rdata = 0.
- Address decode uses addr[31:2] plus addr[1]; addr[0] is ignored.
  - LED_LO = LED_BASE, covers bits [15:0].
  - LED_HI = LED_BASE+2, covers bits [23:16].
  - SW_LO = SW_BASE, covers bits [15:0].
  - SW_HI = SW_BASE+2, covers bits [23:16].
  - Any other address is unmapped.
- LED write: on the rising edge with ioWrite=1:
  - Address LED_LO: led_out[15:0] <= wdata[15:0].
  - Address LED_HI: led_out[23:16] <= wdata[7:0].
  - All other bits hold. Writes to switch or unmapped addresses are ignored.
  - led_out is a register; a new value is visible one clock after the write edge.
- Read path is combinational (single-cycle CPU) and valid in the same cycle as ioRead.
  - SW_LO: io_rdata = {8'b0, stable[15:0]}.
  - SW_HI: io_rdata = {16'b0, stable[23:16]}.
  - LED_LO / LED_HI: read back led_out in the same layout.
  - Unmapped address, or ioRead=0: io_rdata = 0.
- Synchronizer: sync1 <= switch_in, then sync2 <= sync1. Adds 2 clocks of latency.
- Debouncer: one shared counter for the whole 24-bit vector.
  - If sync2 != candidate: candidate <= sync2, counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable <= candidate; counter holds (saturates, no wrap).
  - Else: counter <= counter+1.
  - A change on any bit restarts the count for all bits.
  - Worst-case acceptance latency is 2 + 1 + DEBOUNCE_CYCLES clocks after the input settles.
- Glitches shorter than DEBOUNCE_CYCLES never reach stable.
- Simultaneous ioWrite and ioRead in one cycle: the write commits at the edge. The combinational read returns the pre-edge led_out.
- Reset asserted mid-debounce discards the candidate. After release, stable is 0 until the inputs are stable for the full count again.
- ioWrite with X/Z wdata while unmapped must not alter led_out.

Test Plan:
- Reset: hold rst_n=0 with switch_in=24'hFFFFFF and ioWrite=1 to LED_LO -> led_out=0 and io_rdata=0 throughout; async clear is observed mid-cycle.
- LED halves: with DEBOUNCE_CYCLES=4, write 32'h1234ABCD to LED_LO, then 32'h000000EE to LED_HI -> led_out=24'hEEABCD. ioRead of LED_HI returns 24'h0000EE.
- Unmapped: write 32'hFFFFFFFF to 32'hFFFFFC80 -> led_out unchanged; an ioRead there returns 0.
- Debounce accept: switch_in steps to 24'h5A5A5A and holds -> SW_LO reads 24'h005A5A and SW_HI reads 24'h00005A exactly 2+1+4 clocks later, and not one clock earlier.
- Glitch reject: switch_in pulses 24'h000001 for 3 clocks, then returns to 0 -> stable stays 0 and SW_LO reads 0.
- Restart: bit0 changes, then bit23 changes 2 clocks later -> acceptance is timed from the bit23 change; both bits appear together.
